uart_parity_tx: RTL and testbench
=================================

# uart_parity_tx

Serial transmitter producing the same frame the team's even-parity UART receiver checks: one start bit (0), DATA_BITS data bits LSB first, one parity bit, one stop bit (1). It accepts a parallel word over a valid/ready handshake and drives the serial line, one bit per CLKS_PER_BIT clocks. The block sits on the transmit side of the link. Its output can be looped directly into the receiver for self-test.

## Interface
- DATA_BITS, default 4: data bits per frame (≥1).
- CLKS_PER_BIT, default 1: clocks per bit period (≥1). The default of 1 matches the receiver's one-sample-per-clock operation.
- PARITY_ODD, default 0: 0 selects even parity, so data plus parity carry an even number of 1s. 1 selects odd parity.

Ports:
- clk, input, 1: the single clock. All logic is on the rising edge.
- reset, input, 1: asynchronous, active-high.
- tx_data, input, DATA_BITS: word to send. Sampled only on an accepting edge.
- tx_valid, input, 1: a word is offered.
- tx_ready, output, 1: the block can accept a word this cycle.
- tx, output, 1: serial line, registered, idles high.
- busy, output, 1: high while a frame is in flight.
- done, output, 1: one-cycle pulse during the last clock of the stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- An accept happens on a rising edge where tx_valid && tx_ready. On that edge the block:
  - latches tx_data into a shift register,
  - computes parity = ^tx_data ^ PARITY_ODD,
  - enters START with tx = 0.
- START (1 bit period), then DATA.
- DATA lasts DATA_BITS bit periods. tx = shift[0], and the register shifts right at the end of each period. The bit index runs 0..DATA_BITS-1.
- After DATA, PARITY: tx = latched parity bit for 1 period.
- After PARITY, STOP: tx = 1 for 1 period.
- At the end of STOP:
  - If an accept occurs on that same edge, go to START with no idle gap.
  - Otherwise go to IDLE.
- IDLE: tx = 1. The block waits indefinitely while tx_valid = 0.
- tx_ready = 1 in IDLE, and during the last clock of STOP. It is 0 in all other cases.
- busy = 1 in every state except IDLE.
- tx_data changes while the block is not ready are ignored.
- States are reached only from reset or by the sequence above. Any unreachable encoding returns to IDLE with tx = 1.

## Timing
- Reset value of every output:
  - tx = 1, tx_ready = 1, busy = 0, done = 0.
  - State is IDLE; counters and shift register are 0.
- Reset asserted mid-frame forces tx = 1 immediately (asynchronously), not at the next clock edge, and the frame is abandoned. The receiver then sees a high line and leaves its break state.
- A frame is (DATA_BITS+3)·CLKS_PER_BIT clocks, measured from the accepting edge to the edge that ends STOP.
- Latency: tx falls on the accepting edge itself, with no added cycle. Each bit changes exactly on a bit-period boundary.
- Bit-period counter: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT)+1, and wraps to 0 at each boundary.
- Bit index counter: width $clog2(DATA_BITS)+1.
- Back-to-back throughput is one frame per (DATA_BITS+3)·CLKS_PER_BIT clocks.
- done coincides with tx_ready in STOP. When an accept happens on that edge, done and the new START occur back to back.
- tx_valid deasserted mid-frame has no effect.

## Structure
- Shared package uart_pkg contains:
  - the state typedef (IDLE, START, DATA, PARITY, STOP),
  - the START_BIT = 0, STOP_BIT = 1 and IDLE_LEVEL = 1 constants,
  - a FRAME_BITS(DATA_BITS) = DATA_BITS+3 function.
- One sub-module, uart_baud_tick, which contains the bit-period counter. Inputs: clk, reset, clear (asserted on accept). Output: a tick on the last clock of each bit period.
- The FSM, shift register and parity bit are in the top module.

## Test plan
- **Reset:** after reset, with tx_valid = 0 for 20 cycles:
  - tx = 1, tx_ready = 1, busy = 0, done = 0 throughout.
- **Even-parity frame:** DATA_BITS = 4, CLKS_PER_BIT = 1, tx_data = 4'b1011:
  - tx reads 0,1,1,0,1,1,1, i.e. start, d0..d3, parity 1, stop.
  - busy is high for 7 cycles; done fires on the 7th.
  - Looping tx into the receiver gives valid = 1, error = 0.
- **Zero data:** tx_data = 4'b0000 gives tx 0,0,0,0,0,0,1 (parity 0).
  - With PARITY_ODD = 1, the parity bit is 1, and the receiver flags error.
- **Back-to-back:** 4'hA then 4'h5, with tx_valid held high:
  - tx reads 0,0,1,0,1,0,1 then 0,1,0,1,0,0,1.
  - There is no idle high between frames.
  - tx_ready is high only in each stop cycle.
  - The receiver reports two valid frames.
- **Slow bit rate:** CLKS_PER_BIT = 4, tx_data = 4'b0110:
  - Each bit holds exactly 4 clocks; the frame is 28 clocks.
  - done is one cycle wide.
- **Reset mid-frame:** assert reset during d2:
  - tx goes 1 before the next edge.
  - After release, a new frame of 4'b1111 produces 0,1,1,1,1,0,1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, line levels and frame length helper.
// Imported by the transmitter and its bit-period counter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Bits on the wire per frame: start + data + parity + stop.
  function automatic int FRAME_BITS(input int data_bits);
    return data_bits + 3;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter for the UART transmitter.
// Ports:
//   clk   - clock (rising edge)
//   reset - asynchronous, active-high
//   clear - restart the bit period (asserted on a frame accept)
//   tick  - high during the last clock of each bit period
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Free-running while idle; clear aligns the first period to the accepting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    cnt <= '0;
    else if (clear || cnt == LAST) cnt <= '0;
    else                          cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_parity_tx.sv
// Parity UART transmitter: start(0), DATA_BITS data LSB first, parity, stop(1).
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   tx_data, tx_valid   - word offered for transmission
//   tx_ready            - word accepted on this edge if tx_valid
//   tx                  - registered serial line, idles high
//   busy                - frame in flight
//   done                - pulse during the last clock of the stop bit
module uart_parity_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int            BW       = $clog2(DATA_BITS) + 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(DATA_BITS - 1);
  localparam logic          ODD_BIT  = (PARITY_ODD != 0);

  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_nx;
  logic [BW-1:0]        bit_idx;
  logic                 par;
  logic                 tick;
  logic                 last_stop;
  logic                 accept;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .tick  (tick)
  );

  // Ready in the final stop clock lets a new frame start with no idle gap.
  assign last_stop = (state == STOP) && tick;
  assign tx_ready  = (state == IDLE) || last_stop;
  assign accept    = tx_valid && tx_ready;
  assign busy      = (state != IDLE);
  assign done      = last_stop;
  assign shift_nx  = shift >> 1;

  // tx is computed as the next-bit value so it changes on the boundary edge itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= IDLE_LEVEL;
      shift   <= '0;
      bit_idx <= '0;
      par     <= 1'b0;
    end else if (accept) begin
      state   <= START;
      tx      <= START_BIT;
      shift   <= tx_data;
      bit_idx <= '0;
      par     <= (^tx_data) ^ ODD_BIT;
    end else begin
      case (state)
        IDLE: tx <= IDLE_LEVEL;
        START: if (tick) begin
          state   <= DATA;
          tx      <= shift[0];
          bit_idx <= '0;
        end
        DATA: if (tick) begin
          shift <= shift_nx;
          if (bit_idx == LAST_IDX) begin
            state <= PARITY;
            tx    <= par;
          end else begin
            bit_idx <= bit_idx + BW'(1);
            tx      <= shift_nx[0];
          end
        end
        PARITY: if (tick) begin
          state <= STOP;
          tx    <= STOP_BIT;
        end
        STOP: if (tick) begin
          state <= IDLE;
          tx    <= IDLE_LEVEL;
        end
        default: begin
          state <= IDLE;
          tx    <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_parity_tx.sv
// Bench for uart_parity_tx: three instances (even/1 clk, odd/1 clk, even/4 clk).
module tb_uart_parity_tx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] d   [3];
  logic       v   [3];
  logic       txo [3];
  logic       rdy [3];
  logic       bsy [3];
  logic       dn  [3];

  int checks = 0;
  int errors = 0;

  logic [3:0] pd[$];  // pending data words
  logic [6:0] pe[$];  // expected frames, first bit in MSB

  typedef struct {
    int         sel;
    logic [3:0] data;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  uart_parity_tx #(.DATA_BITS(4), .CLKS_PER_BIT(1), .PARITY_ODD(0)) u0 (
    .clk(clk), .reset(reset), .tx_data(d[0]), .tx_valid(v[0]),
    .tx_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]), .done(dn[0]));
  uart_parity_tx #(.DATA_BITS(4), .CLKS_PER_BIT(1), .PARITY_ODD(1)) u1 (
    .clk(clk), .reset(reset), .tx_data(d[1]), .tx_valid(v[1]),
    .tx_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]), .done(dn[1]));
  uart_parity_tx #(.DATA_BITS(4), .CLKS_PER_BIT(4), .PARITY_ODD(0)) u2 (
    .clk(clk), .reset(reset), .tx_data(d[2]), .tx_valid(v[2]),
    .tx_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]), .done(dn[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame from the line rules: parity makes data+parity ones even (odd if selected).
  function automatic logic [6:0] model(input logic [3:0] data, input bit odd);
    logic [6:0] f;
    int ones;
    ones = $countones(data) + (odd ? 1 : 0);
    f[6] = 1'b0;
    for (int i = 0; i < 4; i++) f[5-i] = data[i];
    f[1] = (ones % 2) == 1;
    f[0] = 1'b1;
    return f;
  endfunction

  task automatic chk_idle(input int sel);
    chk("idle_tx", txo[sel], 1);
    chk("idle_busy", bsy[sel], 0);
    chk("idle_ready", rdy[sel], 1);
    chk("idle_done", dn[sel], 0);
  endtask

  // Sends every queued word on one instance, checking each clock of each frame.
  task automatic run_seq(input int sel, input bit b2b);
    int         cpb;
    int         nclk;
    bit         last;
    logic [6:0] fr;
    cpb  = (sel == 2) ? 4 : 1;
    nclk = FRAME_BITS(4) * cpb;
    @(negedge clk);
    chk("ready_before", rdy[sel], 1);
    v[sel] = 1'b1;
    d[sel] = pd[0];
    while (pd.size() > 0) begin
      void'(pd.pop_front());
      fr = pe.pop_front();
      @(posedge clk);
      for (int k = 0; k < nclk; k++) begin
        @(negedge clk);
        if (k == 0) begin
          v[sel] = b2b && (pd.size() > 0);
          d[sel] = 4'($urandom);  // not ready: must be ignored
        end
        last = (k == nclk - 1);
        chk("tx_bit", txo[sel], fr[6 - k/cpb]);
        chk("busy", bsy[sel], 1);
        chk("done", dn[sel], last);
        chk("ready", rdy[sel], last);
        if (last && pd.size() > 0) begin
          if (!b2b) begin
            @(negedge clk);
            chk_idle(sel);
            repeat ($urandom_range(0, 3)) begin
              @(negedge clk);
              chk("gap_tx", txo[sel], 1);
            end
            v[sel] = 1'b1;
          end
          d[sel] = pd[0];
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{0, 4'b1011, 7'b0110111};
    tbl[1] = '{0, 4'b0000, 7'b0000001};
    tbl[2] = '{1, 4'b0000, 7'b0000011};
    tbl[3] = '{0, 4'b1010, 7'b0010101};
    tbl[4] = '{0, 4'b0101, 7'b0101001};
    tbl[5] = '{2, 4'b0110, 7'b0011001};
    tbl[6] = '{1, 4'b1011, 7'b0110101};

    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b0;
      d[i] = '0;
    end
    reset = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) chk_idle(i);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state holds while nothing is offered.
    repeat (20) begin
      @(negedge clk);
      chk_idle(0);
    end

    // Table of single frames.
    for (int i = 0; i < 7; i++) begin
      pd.push_back(tbl[i].data);
      pe.push_back(tbl[i].exp);
      run_seq(tbl[i].sel, 1'b0);
    end

    // Back-to-back A then 5, valid held high.
    pd.push_back(4'hA); pe.push_back(7'b0010101);
    pd.push_back(4'h5); pe.push_back(7'b0101001);
    run_seq(0, 1'b1);

    // Reset during d2 of 4'b1011 (d2 = 0) must raise tx before the next edge.
    @(negedge clk);
    v[0] = 1'b1;
    d[0] = 4'b1011;
    @(posedge clk);
    @(negedge clk);
    v[0] = 1'b0;
    chk("mid_start", txo[0], 0);
    @(negedge clk);
    chk("mid_d0", txo[0], 1);
    @(negedge clk);
    chk("mid_d1", txo[0], 1);
    @(negedge clk);
    chk("mid_d2", txo[0], 0);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_tx", txo[0], 1);
    chk("rst_async_busy", bsy[0], 0);
    chk("rst_async_ready", rdy[0], 1);
    @(negedge clk);
    reset = 1'b0;
    pd.push_back(4'b1111); pe.push_back(7'b0111101);
    run_seq(0, 1'b0);

    // Randomized batches against the reference model.
    for (int b = 0; b < 12; b++) begin
      int sel;
      int n;
      logic [3:0] w;
      sel = b % 3;
      n   = $urandom_range(2, 4);
      for (int j = 0; j < n; j++) begin
        w = 4'($urandom);
        pd.push_back(w);
        pe.push_back(model(w, sel == 1));
      end
      run_seq(sel, 1'($urandom));
    end

    @(negedge clk);
    for (int i = 0; i < 3; i++) chk_idle(i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
